// File: rtl/vlsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_pkg
// Description : Shared types and helpers for the vector load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package vlsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vlsu_state_e;

    // Lane index width, never narrower than one bit so single-lane builds still elaborate.
    function automatic int lane_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lsu_tag_pipe
// Description : DEPTH-stage shift register of {valid, lane} tags, sync clear.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_tag_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_lane,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_lane
);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_lane [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst || i_clear) begin
                r_valid[k] <= 1'b0;
                r_lane[k]  <= '0;
            end else if (k == 0) begin
                r_valid[k] <= i_valid;
                r_lane[k]  <= i_lane;
            end else begin
                r_valid[k] <= r_valid[(k > 0) ? k - 1 : 0];
                r_lane[k]  <= r_lane[(k > 0) ? k - 1 : 0];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_lane  = r_lane[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vector_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : vector_load_store_unit
// Description : Serialises vector/scalar loads and stores into per-lane accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_load_store_unit
    import vlsu_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic                    req_vector,
    input  logic [ADDR_W-1:0]       req_base,
    input  logic [ADDR_W-1:0]       req_stride,
    input  logic [LANES-1:0]        req_mask,
    input  logic [LANES*LANE_W-1:0] req_wdata,
    input  logic                    abort,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [LANE_W-1:0]       mem_wdata,
    input  logic [LANE_W-1:0]       mem_rdata,
    output logic                    stall,
    output logic                    done,
    output logic [LANES*LANE_W-1:0] rdata
);

    localparam int                    LANE_IDX_W   = lane_idx_w(LANES);
    localparam logic [LANE_IDX_W-1:0] c_LAST_LANE  = LANE_IDX_W'(LANES - 1);
    localparam logic [2:0]            c_DRAIN_LAST = 3'(RD_LAT - 1);

    vlsu_state_e               r_state;
    logic                      r_write;
    logic                      r_vector;
    logic [ADDR_W-1:0]         r_stride;
    logic [LANES-1:0]          r_mask;
    logic [LANES*LANE_W-1:0]   r_wdata;
    logic [ADDR_W-1:0]         r_addr_acc;
    logic [LANE_IDX_W-1:0]     r_lane;
    logic [2:0]                r_drain_cnt;
    logic [ADDR_W-1:0]         r_addr_hold;
    logic [LANE_W-1:0]         r_wdata_hold;
    logic [LANES*LANE_W-1:0]   r_rdata;

    logic                      w_lane_en;
    logic                      w_issue;
    logic                      w_re;
    logic                      w_we;
    logic                      w_last_lane;
    logic [LANE_W-1:0]         w_lane_wdata;
    logic                      w_tag_valid;
    logic [LANE_IDX_W-1:0]     w_tag_lane;

    // Scalar ops always use lane 0 and ignore the mask.
    assign w_lane_en    = r_vector ? r_mask[r_lane] : 1'b1;
    assign w_last_lane  = r_vector ? (r_lane == c_LAST_LANE) : 1'b1;
    assign w_issue      = (r_state == ST_ISSUE) && w_lane_en && !abort;
    assign w_re         = w_issue && !r_write;
    assign w_we         = w_issue && r_write;
    assign w_lane_wdata = r_wdata[r_lane*LANE_W +: LANE_W];

    assign mem_re    = w_re;
    assign mem_we    = w_we;
    assign mem_addr  = w_issue ? r_addr_acc : r_addr_hold;
    assign mem_wdata = w_we ? w_lane_wdata : r_wdata_hold;
    assign done      = (r_state == ST_DONE);
    assign rdata     = r_rdata;

    always_comb begin
        stall = 1'b0;
        case (r_state)
            ST_IDLE:  stall = req_valid;
            ST_ISSUE: stall = 1'b1;
            ST_DRAIN: stall = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_vector    <= 1'b0;
            r_stride    <= '0;
            r_mask      <= '0;
            r_wdata     <= '0;
            r_addr_acc  <= '0;
            r_lane      <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_vector    <= req_vector;
                        r_stride    <= req_stride;
                        r_mask      <= req_mask;
                        r_wdata     <= req_wdata;
                        r_addr_acc  <= req_base;
                        r_lane      <= '0;
                        r_drain_cnt <= '0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_addr_acc <= r_addr_acc + r_stride;
                        if (w_last_lane) begin
                            r_state <= r_write ? ST_DONE : ST_DRAIN;
                        end else begin
                            r_lane <= r_lane + LANE_IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_hold  <= '0;
            r_wdata_hold <= '0;
            r_rdata      <= '0;
        end else begin
            if (w_issue) r_addr_hold <= r_addr_acc;
            if (w_we)    r_wdata_hold <= w_lane_wdata;
            if (r_state == ST_IDLE && req_valid) begin
                r_rdata <= '0;
            end else if (w_tag_valid && !abort) begin
                r_rdata[w_tag_lane*LANE_W +: LANE_W] <= mem_rdata;
            end
        end
    end

    lsu_tag_pipe #(
        .DEPTH (RD_LAT),
        .IDX_W (LANE_IDX_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (reset),
        .i_clear (abort),
        .i_valid (w_re),
        .i_lane  (r_lane),
        .o_valid (w_tag_valid),
        .o_lane  (w_tag_lane)
    );

endmodule
`default_nettype wire
